// File: rtl/proc_pkg.sv
// Shared definitions for the processor skeleton front end.
// Holds default widths, reset PC, fetch-entry layout {pc, insn} and NOP encoding.
package proc_pkg;

   localparam int DEF_ADDR_W   = 12;
   localparam int DEF_DATA_W   = 32;
   localparam int DEF_RESET_PC = 0;

   localparam logic [31:0] NOP_INSN = 32'h0000_0000;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] pc;
      logic [DEF_DATA_W-1:0] insn;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH x WIDTH entries, flush beats push/pop.
// Ports: clock, reset (async high), push/pop/flush, din; count, valid, dout (head).
module fetch_fifo
   import proc_pkg::*;
#(
   parameter  int DEPTH = 2,
   parameter  int WIDTH = DEF_ADDR_W + DEF_DATA_W,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [CW-1:0]    count,
   output logic             valid,
   output logic [WIDTH-1:0] dout
);

   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign valid   = (count != '0);
   assign do_push = push & ~flush;
   assign do_pop  = pop & valid & ~flush;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   no_overflow: assert property (
      @(posedge clock) disable iff (reset)
      !(do_push && !do_pop && count == FULL));

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: drives imem address, queues returned insns, hands them to decode.
// Ports: clock, reset, address_imem/q_imem (imem), insn_out/pc_out/pc_plus1_out,
// valid_out/insn_ready (decode), redirect/redirect_pc, perf_fetched/perf_flushes.
// FETCH_PERF_CNT_EN enables the perf counters; otherwise they read 0.
module fetch_unit
   import proc_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int DEPTH    = 2,
   parameter int RESET_PC = DEF_RESET_PC
) (
   input  logic              clock,
   input  logic              reset,
   output logic [ADDR_W-1:0] address_imem,
   input  logic [DATA_W-1:0] q_imem,
   output logic [DATA_W-1:0] insn_out,
   output logic [ADDR_W-1:0] pc_out,
   output logic [ADDR_W-1:0] pc_plus1_out,
   output logic              valid_out,
   input  logic              insn_ready,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [31:0]       perf_fetched,
   output logic [31:0]       perf_flushes
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

   logic [ADDR_W-1:0]        pc;
   logic                     inflight;
   logic [ADDR_W-1:0]        inflight_pc;
   logic                     pop;
   logic                     push;
   logic                     issue;
   logic [CW-1:0]            count;
   logic [CW:0]              occ;
   logic [ADDR_W+DATA_W-1:0] head;

   assign pop  = valid_out & insn_ready;
   assign push = inflight & ~redirect;

   // Credit check: slots already owned plus the one about to be issued.
   assign occ   = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
   assign issue = ~redirect & (occ < DEPTH_V);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc          <= ADDR_W'(RESET_PC);
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else if (redirect) begin
         pc       <= redirect_pc;
         inflight <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            inflight_pc <= pc;
            pc          <= pc + ADDR_W'(1);
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ADDR_W + DATA_W)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (redirect),
      .din   ({inflight_pc, q_imem}),
      .count (count),
      .valid (valid_out),
      .dout  (head)
   );

   assign address_imem = pc;
   assign insn_out     = valid_out ? head[DATA_W-1:0] : DATA_W'(NOP_INSN);
   assign pc_out       = valid_out ? head[DATA_W+:ADDR_W] : '0;
   assign pc_plus1_out = pc_out + ADDR_W'(1);

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetched_q;
   logic [31:0] flushes_q;

   // A pop coinciding with a redirect is squashed, so it is not counted.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fetched_q <= '0;
         flushes_q <= '0;
      end else begin
         if (redirect)       flushes_q <= flushes_q + 32'd1;
         if (pop & ~redirect) fetched_q <= fetched_q + 32'd1;
      end
   end

   assign perf_fetched = fetched_q;
   assign perf_flushes = flushes_q;
`else
   assign perf_fetched = '0;
   assign perf_flushes = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a 1-cycle synchronous imem model.
// Table-driven startup/backpressure, directed redirect/wrap/reset, random stream vs model.
module tb_fetch_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [11:0] address_imem;
   logic [31:0] q_imem;
   logic [31:0] insn_out;
   logic [11:0] pc_out;
   logic [11:0] pc_plus1_out;
   logic        valid_out;
   logic        insn_ready;
   logic        redirect;
   logic [11:0] redirect_pc;
   logic [31:0] perf_fetched;
   logic [31:0] perf_flushes;

   int tests = 0;
   int fails = 0;

   logic [11:0] exp_next;
   int          exp_fetch;
   int          exp_flush;
   logic        hold_chk;

   fetch_unit dut (
      .clock        (clock),
      .reset        (reset),
      .address_imem (address_imem),
      .q_imem       (q_imem),
      .insn_out     (insn_out),
      .pc_out       (pc_out),
      .pc_plus1_out (pc_plus1_out),
      .valid_out    (valid_out),
      .insn_ready   (insn_ready),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .perf_fetched (perf_fetched),
      .perf_flushes (perf_flushes)
   );

   always #5 clock = ~clock;

   always @(posedge clock) q_imem <= 32'h1000_0000 + {20'h0, address_imem};

   function automatic logic [31:0] imem_word(input logic [11:0] a);
      return 32'h1000_0000 + {20'h0, a};
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One cycle: apply inputs, update the reference stream model from the
   // handshake seen this cycle, then advance past the edge.
   task automatic cyc(input logic r, input logic rd, input logic [11:0] rpc);
      logic [11:0] hpc;
      logic [31:0] hinsn;
      logic        hold;
      insn_ready  = r;
      redirect    = rd;
      redirect_pc = rpc;
      hpc   = pc_out;
      hinsn = insn_out;
      hold  = valid_out & ~r & ~rd;
      if (rd) begin
         exp_next = rpc;
         exp_flush++;
      end else if (valid_out && r) begin
         chk("stream_pc", {52'h0, pc_out}, {52'h0, exp_next});
         chk("stream_insn", {32'h0, insn_out}, {32'h0, imem_word(exp_next)});
         chk("stream_pc1", {52'h0, pc_plus1_out}, {52'h0, exp_next + 12'd1});
         exp_next = exp_next + 12'd1;
         exp_fetch++;
      end
      @(posedge clock);
      #1;
      if (hold_chk && hold) begin
         chk("hold_valid", {63'h0, valid_out}, 64'h1);
         chk("hold_pc", {52'h0, pc_out}, {52'h0, hpc});
         chk("hold_insn", {32'h0, insn_out}, {32'h0, hinsn});
      end
   endtask

   task automatic model_reset();
      exp_next  = 12'h000;
      exp_fetch = 0;
      exp_flush = 0;
   endtask

   task automatic expect_head(input string name, input logic [11:0] pc);
      chk({name, "_valid"}, {63'h0, valid_out}, 64'h1);
      chk({name, "_pc"}, {52'h0, pc_out}, {52'h0, pc});
      chk({name, "_insn"}, {32'h0, insn_out}, {32'h0, imem_word(pc)});
   endtask

   typedef struct {
      logic        r;
      logic        v;
      logic [11:0] pc;
      logic [11:0] addr;
   } vec_t;

   vec_t tbl[16];

   initial begin
      int          waited;
      logic [31:0] exp_pf;
      logic [31:0] exp_pl;

      insn_ready  = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 12'h000;
      hold_chk    = 1'b0;
      model_reset();

      for (int i = 0; i < 16; i++) begin
         tbl[i].r    = (i >= 6);
         tbl[i].v    = (i >= 1);
         tbl[i].pc   = (i < 6) ? 12'h000 : 12'(i - 5);
         tbl[i].addr = (i == 0) ? 12'h001 : (i < 6) ? 12'h002 : 12'(i - 3);
      end

      #1 reset = 1'b1;
      #1;
      chk("rst_addr", {52'h0, address_imem}, 64'h0);
      chk("rst_valid", {63'h0, valid_out}, 64'h0);
      chk("rst_insn", {32'h0, insn_out}, 64'h0);
      chk("rst_pc", {52'h0, pc_out}, 64'h0);
      chk("rst_pf", {32'h0, perf_fetched}, 64'h0);
      chk("rst_pl", {32'h0, perf_flushes}, 64'h0);

      @(posedge clock);
      #1 reset = 1'b0;

      // Startup, backpressure, release and streaming.
      hold_chk = 1'b1;
      for (int i = 0; i < 16; i++) begin
         cyc(tbl[i].r, 1'b0, 12'h000);
         chk($sformatf("tbl%0d_valid", i), {63'h0, valid_out}, {63'h0, tbl[i].v});
         chk($sformatf("tbl%0d_addr", i), {52'h0, address_imem},
             {52'h0, tbl[i].addr});
         if (tbl[i].v) begin
            chk($sformatf("tbl%0d_pc", i), {52'h0, pc_out}, {52'h0, tbl[i].pc});
            chk($sformatf("tbl%0d_insn", i), {32'h0, insn_out},
                {32'h0, imem_word(tbl[i].pc)});
         end
      end
      chk("start_pc1", {52'h0, pc_plus1_out}, {52'h0, tbl[15].pc + 12'd1});

      // Redirect while a fetch is in flight and the queue holds an entry.
      cyc(1'b1, 1'b1, 12'h040);
      chk("redir_valid_t1", {63'h0, valid_out}, 64'h0);
      chk("redir_addr_t1", {52'h0, address_imem}, 64'h040);
      cyc(1'b1, 1'b0, 12'h000);
      chk("redir_valid_t2", {63'h0, valid_out}, 64'h0);
      cyc(1'b1, 1'b0, 12'h000);
      expect_head("redir_t3", 12'h040);
      cyc(1'b1, 1'b0, 12'h000);
      expect_head("redir_t4", 12'h041);

      // PC wrap.
      cyc(1'b1, 1'b1, 12'hFFE);
      chk("wrap_valid", {63'h0, valid_out}, 64'h0);
      cyc(1'b1, 1'b0, 12'h000);
      cyc(1'b1, 1'b0, 12'h000);
      expect_head("wrap_ffe", 12'hFFE);
      cyc(1'b1, 1'b0, 12'h000);
      expect_head("wrap_fff", 12'hFFF);
      chk("wrap_pc1", {52'h0, pc_plus1_out}, 64'h000);
      cyc(1'b1, 1'b0, 12'h000);
      expect_head("wrap_000", 12'h000);
      cyc(1'b1, 1'b0, 12'h000);
      expect_head("wrap_001", 12'h001);

      // Back-to-back redirects: the last one wins.
      cyc(1'b1, 1'b1, 12'h100);
      cyc(1'b1, 1'b1, 12'h200);
      chk("b2b_addr", {52'h0, address_imem}, 64'h200);
      cyc(1'b1, 1'b0, 12'h000);
      cyc(1'b1, 1'b0, 12'h000);
      expect_head("b2b", 12'h200);

      // Random traffic against the stream model.
      for (int i = 0; i < 600; i++) begin
         logic        r;
         logic        rd;
         logic [11:0] rpc;
         r   = ($urandom_range(0, 9) < 7);
         rd  = ($urandom_range(0, 19) == 0);
         rpc = ($urandom_range(0, 3) == 0) ? 12'(12'hFFC + $urandom_range(0, 3))
                                           : 12'($urandom_range(0, 4095));
         cyc(r, rd, rpc);
      end

      waited = 0;
      cyc(1'b1, 1'b0, 12'h000);
      while (!valid_out && waited < 5) begin
         cyc(1'b1, 1'b0, 12'h000);
         waited++;
      end
      chk("live_valid", {63'h0, valid_out}, 64'h1);

      // Asynchronous reset between edges mid-stream.
      #3 reset = 1'b1;
      #1;
      chk("arst_valid", {63'h0, valid_out}, 64'h0);
      chk("arst_addr", {52'h0, address_imem}, 64'h0);
      chk("arst_pc", {52'h0, pc_out}, 64'h0);
      chk("arst_pf", {32'h0, perf_fetched}, 64'h0);
      model_reset();
      @(posedge clock);
      #1 reset = 1'b0;

      // Ten pops then two redirects for the perf counters.
      waited = 0;
      while (exp_fetch < 10 && waited < 40) begin
         cyc(1'b1, 1'b0, 12'h000);
         waited++;
      end
      chk("perf_pop_count", 64'(exp_fetch), 64'd10);
      cyc(1'b0, 1'b1, 12'h300);
      cyc(1'b0, 1'b1, 12'h300);
`ifdef FETCH_PERF_CNT_EN
      exp_pf = 32'(exp_fetch);
      exp_pl = 32'(exp_flush);
`else
      exp_pf = 32'h0;
      exp_pl = 32'h0;
`endif
      chk("perf_fetched", {32'h0, perf_fetched}, {32'h0, exp_pf});
      chk("perf_flushes", {32'h0, perf_flushes}, {32'h0, exp_pl});
      cyc(1'b0, 1'b0, 12'h000);
      cyc(1'b0, 1'b0, 12'h000);
      chk("resume_pc", {52'h0, pc_out}, 64'h300);

      #3 reset = 1'b1;
      #1;
      chk("perf_clr_f", {32'h0, perf_fetched}, 64'h0);
      chk("perf_clr_l", {32'h0, perf_flushes}, 64'h0);
      @(posedge clock);
      #1 reset = 1'b0;
      model_reset();
      cyc(1'b0, 1'b0, 12'h000);
      cyc(1'b0, 1'b0, 12'h000);
      expect_head("post_rst", 12'h000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
